multicycle_controller: RTL and testbench

- Multicycle sequencer for the MIPS datapath. A single shared memory port serves both instruction fetch and data access.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives all datapath enables and muxes per state.
- Handles variable-latency memory via a req/ready handshake with timeout, and counts retired instructions.
- Sits between the IR/ALU/register file/PC and the unified memory.

---
 rtl/multicycle_controller_if.sv | 22 ++
 rtl/multicycle_controller.sv | 198 +++++++++++++++++++
 tb/tb_multicycle_controller.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Unified memory port between the multicycle controller and memory.
// The controller drives the request; memory answers with mem_ready.
interface multicycle_controller_if;
    logic mem_req;
    logic mem_we;
    logic i_or_d;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output i_or_d,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  i_or_d,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB with a shared
// memory port, access timeout and a retired-instruction counter.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_controller_if.master bus,
    input  logic [31:0]          ir,
    input  logic                 zero,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic [1:0]           pc_src,
    output logic [1:0]           alu_src_b,
    output logic                 sign_ext,
    output logic                 reg_write,
    output logic                 reg_dst,
    output logic                 mem2reg,
    output logic                 pc2reg,
    output logic [2:0]           state,
    output logic                 halt,
    output logic                 illegal,
    output logic                 bus_err,
    output logic [CNT_W-1:0]     retire_cnt
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } st_t;

    st_t st, nx;
    logic [TW-1:0] wcnt;
    logic retire, set_ill, set_berr, tmo;
    logic mem_req, mem_we, i_or_d;

    logic [5:0] op, fn;
    logic is_r, r_ok, i_ok, legal, is_halt;
    logic is_j, is_jal, is_jr, is_shift, is_beq, is_bne;
    logic is_lw, is_sw, is_imm, is_sext;
    logic unused_ir;

    assign op        = ir[31:26];
    assign fn        = ir[5:0];
    assign unused_ir = ^ir[25:6];

    assign is_r  = (op == 6'h00);
    assign r_ok  = fn inside {6'h00, 6'h02, 6'h08, 6'h20, 6'h22,
                              6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h3f};
    assign i_ok  = op inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0a,
                              6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h23, 6'h2b,
                              6'h3f};
    assign legal = is_r ? r_ok : i_ok;

    assign is_halt  = (is_r && fn == 6'h3f) || (op == 6'h3f);
    assign is_j     = (op == 6'h02);
    assign is_jal   = (op == 6'h03);
    assign is_jr    = is_r && (fn == 6'h08);
    assign is_shift = is_r && (fn == 6'h00 || fn == 6'h02);
    assign is_beq   = (op == 6'h04);
    assign is_bne   = (op == 6'h05);
    assign is_lw    = (op == 6'h23);
    assign is_sw    = (op == 6'h2b);
    assign is_imm   = op inside {6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e,
                                 6'h0f, 6'h23, 6'h2b};
    assign is_sext  = op inside {6'h08, 6'h0a, 6'h04, 6'h05,
                                 6'h23, 6'h2b};

    // Last permitted wait cycle; a mem_ready here still completes.
    assign tmo = (wcnt == TW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= S_FETCH;
            wcnt       <= '0;
            retire_cnt <= '0;
            illegal    <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            st <= nx;
            if (nx != st)
                wcnt <= '0;
            else if (mem_req && !bus.mem_ready)
                wcnt <= wcnt + TW'(1);
            if (retire)
                retire_cnt <= retire_cnt + CNT_W'(1);
            if (set_ill)
                illegal <= 1'b1;
            if (set_berr)
                bus_err <= 1'b1;
        end
    end

    always_comb begin
        nx        = st;
        retire    = 1'b0;
        set_ill   = 1'b0;
        set_berr  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        i_or_d    = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'b00;
        alu_src_b = 2'b00;
        sign_ext  = 1'b0;
        reg_write = 1'b0;
        reg_dst   = 1'b0;
        mem2reg   = 1'b0;
        pc2reg    = 1'b0;
        if (rst_n) begin
            case (st)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        nx       = S_DECODE;
                    end else if (tmo) begin
                        set_berr = 1'b1;
                        nx       = S_HALT;
                    end
                end
                S_DECODE: begin
                    if (!legal) begin
                        set_ill = 1'b1;
                        nx      = S_HALT;
                    end else if (is_halt) begin
                        nx = S_HALT;
                    end else if (is_j || is_jal) begin
                        pc_write  = 1'b1;
                        pc_src    = 2'b10;
                        reg_write = is_jal;
                        pc2reg    = is_jal;
                        retire    = 1'b1;
                        nx        = S_FETCH;
                    end else if (is_jr) begin
                        pc_write = 1'b1;
                        pc_src   = 2'b11;
                        retire   = 1'b1;
                        nx       = S_FETCH;
                    end else begin
                        nx = S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_src_b = is_shift ? 2'b10 : (is_imm ? 2'b01 : 2'b00);
                    sign_ext  = is_sext;
                    if (is_beq || is_bne) begin
                        pc_write = is_beq ? zero : !zero;
                        pc_src   = 2'b01;
                        retire   = 1'b1;
                        nx       = S_FETCH;
                    end else if (is_lw || is_sw) begin
                        nx = S_MEM;
                    end else begin
                        nx = S_WB;
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    i_or_d  = 1'b1;
                    mem_we  = is_sw;
                    if (bus.mem_ready) begin
                        retire = is_sw;
                        nx     = is_sw ? S_FETCH : S_WB;
                    end else if (tmo) begin
                        set_berr = 1'b1;
                        nx       = S_HALT;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = is_r;
                    mem2reg   = is_lw;
                    retire    = 1'b1;
                    nx        = S_FETCH;
                end
                S_HALT: nx = S_HALT;
                default: nx = S_FETCH;
            endcase
        end
    end

    assign bus.mem_req = mem_req;
    assign bus.mem_we  = mem_we;
    assign bus.i_or_d  = i_or_d;
    assign state       = st;
    assign halt        = (st == S_HALT);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller with MEM_TIMEOUT=4.
// Inputs change just after posedge; outputs are sampled 1ns later.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ir;
    logic        zero;
    logic        ir_write, pc_write, sign_ext, reg_write;
    logic        reg_dst, mem2reg, pc2reg, halt, illegal, bus_err;
    logic [1:0]  pc_src, alu_src_b;
    logic [2:0]  state;
    logic [31:0] retire_cnt;

    int total = 0;
    int bad   = 0;

    multicycle_controller_if bus ();

    multicycle_controller #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .ir(ir), .zero(zero),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_b(alu_src_b), .sign_ext(sign_ext),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem2reg(mem2reg),
        .pc2reg(pc2reg), .state(state), .halt(halt), .illegal(illegal),
        .bus_err(bus_err), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ir = 32'h0;
        zero = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_ir_write", 32'(ir_write), 32'd0);
        chk("rst_cnt", retire_cnt, 32'd0);
        chk("rst_flags", 32'({halt, illegal, bus_err}), 32'd0);
        tick(); tick();
        rst_n = 1'b1;

        // add $3,$1,$2
        ir = 32'h00221820;
        #1;
        chk("add_f_state", 32'(state), 32'd0);
        chk("add_f_en", 32'({bus.mem_req, bus.i_or_d, ir_write, pc_write}), 32'b1011);
        tick();
        chk("add_d_state", 32'(state), 32'd1);
        chk("add_d_rw", 32'(reg_write), 32'd0);
        tick();
        chk("add_e_state", 32'(state), 32'd2);
        chk("add_e_alub", 32'(alu_src_b), 32'd0);
        chk("add_e_rw", 32'(reg_write), 32'd0);
        tick();
        chk("add_wb_state", 32'(state), 32'd4);
        chk("add_wb_rw_dst", 32'({reg_write, reg_dst, mem2reg}), 32'b110);
        tick();
        chk("add_done_state", 32'(state), 32'd0);
        chk("add_cnt", retire_cnt, 32'd1);

        // lw with 3 wait cycles in MEM (ready on the 4th: boundary)
        ir = 32'h8C220004;
        tick(); tick();
        chk("lw_e_state", 32'(state), 32'd2);
        chk("lw_e_alub_sext", 32'({alu_src_b, sign_ext}), 32'b011);
        tick();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_m_wait", 32'({state, bus.mem_req, bus.i_or_d, bus.mem_we}), 32'b011110);
            tick();
        end
        bus.mem_ready = 1'b1;
        #1;
        chk("lw_m_ready", 32'({state, bus.mem_req, bus.i_or_d}), 32'b01111);
        tick();
        chk("lw_wb", 32'({state, reg_write, reg_dst, mem2reg}), 32'b100101);
        chk("lw_no_buserr", 32'(bus_err), 32'd0);
        tick();
        chk("lw_cnt", retire_cnt, 32'd2);

        // beq taken, then bne not taken, both with zero=1
        ir = 32'h10220003;
        zero = 1'b1;
        tick(); tick();
        chk("beq_e", 32'({state, pc_write, pc_src, sign_ext}), 32'b0101011);
        tick();
        chk("beq_next", 32'(state), 32'd0);
        ir = 32'h14220003;
        tick(); tick();
        chk("bne_e", 32'({state, pc_write, pc_src}), 32'b010001);
        tick();
        chk("bne_cnt", retire_cnt, 32'd4);
        zero = 1'b0;

        // jal: completes in DECODE
        ir = 32'h0C000010;
        tick();
        chk("jal_d", 32'({state, pc_write, pc_src, reg_write, pc2reg}), 32'b00111011);
        tick();
        chk("jal_next", 32'(state), 32'd0);
        chk("jal_cnt", retire_cnt, 32'd5);

        // sll: shamt operand
        ir = 32'h00021080;
        tick(); tick();
        chk("sll_e_alub", 32'(alu_src_b), 32'd2);
        tick(); tick();

        // andi: zero-extended immediate, writes rt
        ir = 32'h30220004;
        tick(); tick();
        chk("andi_e", 32'({alu_src_b, sign_ext}), 32'b010);
        tick();
        chk("andi_wb_dst", 32'({state, reg_write, reg_dst}), 32'b10010);
        tick();

        // sw: write in MEM, retires straight to FETCH
        ir = 32'hAC220004;
        tick(); tick(); tick();
        chk("sw_m", 32'({state, bus.mem_req, bus.i_or_d, bus.mem_we}), 32'b011111);
        tick();
        chk("sw_next", 32'(state), 32'd0);
        chk("sw_cnt", retire_cnt, 32'd8);

        // fetch timeout: four wait cycles without ready
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_fetch_wait", 32'({state, ir_write, pc_write}), 32'd0);
            tick();
        end
        chk("to_state", 32'(state), 32'd5);
        chk("to_flags", 32'({halt, illegal, bus_err}), 32'b101);
        chk("to_mem_req", 32'(bus.mem_req), 32'd0);
        bus.mem_ready = 1'b1;
        tick();
        chk("to_sticky", 32'({state, halt, bus_err, bus.mem_req}), 32'b101110);
        chk("to_cnt", retire_cnt, 32'd8);

        // asynchronous reset pulse mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("rp_state", 32'(state), 32'd0);
        chk("rp_flags", 32'({halt, illegal, bus_err, bus.mem_req}), 32'd0);
        chk("rp_cnt", retire_cnt, 32'd0);
        tick();
        rst_n = 1'b1;

        // halt opcode 0x3F: not illegal, not retired
        ir = 32'hFC000000;
        tick(); tick();
        chk("h3f_state", 32'(state), 32'd5);
        chk("h3f_flags", 32'({halt, illegal, bus_err}), 32'b100);
        chk("h3f_cnt", retire_cnt, 32'd0);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // opcode 0x3E: illegal
        ir = 32'hF8000000;
        tick(); tick();
        chk("h3e_state", 32'(state), 32'd5);
        chk("h3e_flags", 32'({halt, illegal, bus_err}), 32'b110);
        tick();
        chk("h3e_sticky", 32'({halt, illegal, bus.mem_req}), 32'b110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
